// File: rtl/vga_wb_arbiter.sv
// vga_wb_arbiter: shares the VGA core's WISHBONE read master between the
// video-memory fetch, hardware-cursor fetch and CLUT lookup. One owner at a
// time runs a 1/2/4/8-beat burst; a starvation counter guarantees the CLUT
// eventually wins, and a watchdog turns a silent slave into an error.
//
//   state  | meaning
//   IDLE   | bus released, arbitrating among pending requests
//   BUS    | owner's burst in progress, waiting on ACK_I/ERR_I
module vga_wb_arbiter #(
  parameter int TO_W       = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK_I,
  input  logic        nRESET,
  input  logic        RST_I,
  input  logic        ctrl_ven,
  input  logic [2:0]  req,
  input  logic [1:0]  blen0,
  input  logic [1:0]  blen1,
  input  logic [1:0]  blen2,
  input  logic [29:0] adr0,
  input  logic [29:0] adr1,
  input  logic [29:0] adr2,
  output logic [2:0]  gnt,
  output logic [2:0]  ack,
  output logic [2:0]  err,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        CAB_O,
  output logic        WE_O,
  output logic [3:0]  SEL_O,
  output logic [29:0] ADR_O,
  input  logic        ACK_I,
  input  logic        ERR_I,
  output logic        SINT
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [SW-1:0]   STARVE_ONE = SW'(1);
  localparam logic [TO_W-1:0] WD_ONE     = TO_W'(1);
  // The cycle that would bring the watchdog to all-ones ends the cycle.
  localparam logic [TO_W-1:0] WD_LAST    = {{(TO_W-1){1'b1}}, 1'b0};

  typedef enum logic {S_IDLE, S_BUS} state_t;

  state_t         state_q, state_d;
  logic [2:0]     gnt_q, gnt_d;
  logic [2:0]     err_q, err_d;
  logic           sint_q, sint_d;
  logic           cyc_q, cyc_d;
  logic           cab_q, cab_d;
  logic [29:0]    adr_q, adr_d;
  logic [2:0]     beat_q, beat_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic [SW-1:0]  starve_q, starve_d;

  logic [2:0]     win;
  logic [1:0]     win_blen;
  logic [29:0]    win_adr;
  logic [2:0]     win_beats;

  // Pick the winner: starved CLUT first, then fixed vmem > cursor > clut.
  always_comb begin
    win      = 3'b000;
    win_blen = 2'b00;
    win_adr  = 30'd0;
    if (req[2] && (starve_q == STARVE_LIM)) begin
      win = 3'b100;
    end else if (req[0]) begin
      win = 3'b001;
    end else if (req[1]) begin
      win = 3'b010;
    end else if (req[2]) begin
      win = 3'b100;
    end
    case (win)
      3'b001:  begin win_blen = blen0; win_adr = adr0; end
      3'b010:  begin win_blen = blen1; win_adr = adr1; end
      3'b100:  begin win_blen = blen2; win_adr = adr2; end
      default: begin win_blen = 2'b00; win_adr = 30'd0; end
    endcase
    case (win_blen)
      2'b00:   win_beats = 3'd0;
      2'b01:   win_beats = 3'd1;
      2'b10:   win_beats = 3'd3;
      default: win_beats = 3'd7;
    endcase
  end

  // Next-state logic for the arbiter/burst sequencer.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    err_d    = 3'b000;
    sint_d   = 1'b0;
    cyc_d    = cyc_q;
    cab_d    = cab_q;
    adr_d    = adr_q;
    beat_d   = beat_q;
    wd_d     = wd_q;
    starve_d = starve_q;
    if (!req[2]) starve_d = '0;

    if (!ctrl_ven) begin
      // Abort silently: no error reported for a disabled display.
      state_d  = S_IDLE;
      gnt_d    = 3'b000;
      cyc_d    = 1'b0;
      cab_d    = 1'b0;
      starve_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req != 3'b000) begin
            state_d = S_BUS;
            gnt_d   = win;
            cyc_d   = 1'b1;
            adr_d   = win_adr;
            beat_d  = win_beats;
            cab_d   = (win_blen != 2'b00);
            wd_d    = '0;
            if (win[2]) begin
              starve_d = '0;
            end else if (req[2] && (starve_q != STARVE_LIM)) begin
              starve_d = starve_q + STARVE_ONE;
            end
          end
        end
        S_BUS: begin
          if (ERR_I || (!ACK_I && (wd_q == WD_LAST))) begin
            state_d = S_IDLE;
            gnt_d   = 3'b000;
            cyc_d   = 1'b0;
            cab_d   = 1'b0;
            err_d   = gnt_q;
            sint_d  = 1'b1;
          end else if (ACK_I) begin
            wd_d = '0;
            if (beat_q != 3'd0) begin
              adr_d  = adr_q + 30'd1;
              beat_d = beat_q - 3'd1;
            end else begin
              state_d = S_IDLE;
              gnt_d   = 3'b000;
              cyc_d   = 1'b0;
              cab_d   = 1'b0;
            end
          end else begin
            wd_d = wd_q + WD_ONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Register all state; RST_I is a synchronous twin of nRESET.
  always_ff @(posedge CLK_I or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= S_IDLE;
      gnt_q    <= 3'b000;
      err_q    <= 3'b000;
      sint_q   <= 1'b0;
      cyc_q    <= 1'b0;
      cab_q    <= 1'b0;
      adr_q    <= 30'd0;
      beat_q   <= 3'd0;
      wd_q     <= '0;
      starve_q <= '0;
    end else if (RST_I) begin
      state_q  <= S_IDLE;
      gnt_q    <= 3'b000;
      err_q    <= 3'b000;
      sint_q   <= 1'b0;
      cyc_q    <= 1'b0;
      cab_q    <= 1'b0;
      adr_q    <= 30'd0;
      beat_q   <= 3'd0;
      wd_q     <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      err_q    <= err_d;
      sint_q   <= sint_d;
      cyc_q    <= cyc_d;
      cab_q    <= cab_d;
      adr_q    <= adr_d;
      beat_q   <= beat_d;
      wd_q     <= wd_d;
      starve_q <= starve_d;
    end
  end

  // An erroring beat carries no data, so ERR_I suppresses the strobe.
  assign ack   = gnt_q & {3{ACK_I & ~ERR_I}};
  assign gnt   = gnt_q;
  assign err   = err_q;
  assign SINT  = sint_q;
  assign CYC_O = cyc_q;
  assign STB_O = cyc_q;
  assign CAB_O = cab_q;
  assign ADR_O = adr_q;
  assign WE_O  = 1'b0;
  assign SEL_O = 4'b1111;

endmodule

// File: tb/tb_vga_wb_arbiter.sv
// Bench for vga_wb_arbiter: directed stimulus pushes expected ack/err events
// into a queue; a monitor pops and compares whenever the DUT strobes.
module tb_vga_wb_arbiter;

  logic        CLK_I = 1'b0;
  logic        nRESET, RST_I, ctrl_ven;
  logic [2:0]  req;
  logic [1:0]  blen0, blen1, blen2;
  logic [29:0] adr0, adr1, adr2;
  logic [2:0]  gnt, ack, err;
  logic        CYC_O, STB_O, CAB_O, WE_O, SINT;
  logic [3:0]  SEL_O;
  logic [29:0] ADR_O;
  logic        ACK_I, ERR_I;

  always #5 CLK_I = ~CLK_I;

  vga_wb_arbiter #(.TO_W(3), .STARVE_MAX(4)) dut (
    .CLK_I(CLK_I), .nRESET(nRESET), .RST_I(RST_I), .ctrl_ven(ctrl_ven),
    .req(req), .blen0(blen0), .blen1(blen1), .blen2(blen2),
    .adr0(adr0), .adr1(adr1), .adr2(adr2),
    .gnt(gnt), .ack(ack), .err(err),
    .CYC_O(CYC_O), .STB_O(STB_O), .CAB_O(CAB_O), .WE_O(WE_O),
    .SEL_O(SEL_O), .ADR_O(ADR_O), .ACK_I(ACK_I), .ERR_I(ERR_I), .SINT(SINT)
  );

  typedef struct {
    bit          is_err;
    logic [2:0]  vec;
    logic [29:0] adr;
    logic        cab;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  bit   gap_chk = 1'b0;
  int   slave_mode = 0;   // 0: ack every cycle, 1: err after err_after acks, 2: stall
  int   err_after = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
  endtask

  task automatic push_ack(input logic [2:0] v, input logic [29:0] a, input logic c);
    exp_t e;
    e.is_err = 1'b0; e.vec = v; e.adr = a; e.cab = c;
    sb_q.push_back(e);
  endtask

  task automatic push_err(input logic [2:0] v);
    exp_t e;
    e.is_err = 1'b1; e.vec = v; e.adr = 30'd0; e.cab = 1'b0;
    sb_q.push_back(e);
  endtask

  task automatic wait_owner(input logic [2:0] mask, input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK_I); #2;
      if ((gnt & mask) != 3'b000) return;
    end
    n_chk++;
    $display("FAIL %s: timeout, gnt=%b expected any of %b", name, gnt, mask);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK_I); #2;
      if (!CYC_O && sb_q.size() == 0) return;
    end
    n_chk++;
    $display("FAIL %s: timeout, CYC_O=%b pending=%0d expected 0 and 0", name, CYC_O, sb_q.size());
  endtask

  // Slave model: drives ACK_I/ERR_I for the next rising edge.
  initial begin
    int beat_seen;
    beat_seen = 0;
    ACK_I = 1'b0;
    ERR_I = 1'b0;
    forever begin
      @(negedge CLK_I);
      if (!CYC_O) begin
        ACK_I = 1'b0; ERR_I = 1'b0; beat_seen = 0;
      end else begin
        case (slave_mode)
          0: begin ACK_I = 1'b1; ERR_I = 1'b0; end
          1: begin
            if (beat_seen == err_after) begin
              ACK_I = 1'b0; ERR_I = 1'b1;
            end else begin
              ACK_I = 1'b1; ERR_I = 1'b0; beat_seen++;
            end
          end
          default: begin ACK_I = 1'b0; ERR_I = 1'b0; end
        endcase
      end
    end
  end

  // Monitor: pops expectations on every ack/err strobe, checks idle gaps.
  initial begin
    exp_t e;
    logic prev_cyc;
    int   gap;
    prev_cyc = 1'b0;
    gap = 0;
    forever begin
      @(negedge CLK_I); #1;
      if (ack != 3'b000) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_ack: got ack=%b adr=0x%0h expected no strobe", ack, ADR_O);
        end else begin
          e = sb_q.pop_front();
          chk("ack_kind", 32'(0), 32'(e.is_err));
          chk("ack_vec", 32'(ack), 32'(e.vec));
          chk("ack_adr", 32'(ADR_O), 32'(e.adr));
          chk("ack_cab", 32'(CAB_O), 32'(e.cab));
        end
      end
      if (err != 3'b000 || SINT) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_err: got err=%b SINT=%b expected none", err, SINT);
        end else begin
          e = sb_q.pop_front();
          chk("err_kind", 32'(1), 32'(e.is_err));
          chk("err_vec", 32'(err), 32'(e.vec));
          chk("err_sint", 32'(SINT), 32'(1));
          chk("err_cyc_low", 32'(CYC_O), 32'(0));
        end
      end
      if (CYC_O) begin
        if (!prev_cyc && gap_chk) chk("idle_gap", 32'(gap), 32'(1));
        gap = 0;
      end else begin
        gap++;
      end
      prev_cyc = CYC_O;
    end
  end

  initial begin
    int cnt;
    nRESET = 1'b0; RST_I = 1'b0; ctrl_ven = 1'b1; req = 3'b000;
    blen0 = 2'b00; blen1 = 2'b00; blen2 = 2'b00;
    adr0 = 30'd0; adr1 = 30'd0; adr2 = 30'd0;
    repeat (2) @(negedge CLK_I);
    chk("rst_cyc", 32'(CYC_O), 32'(0));
    chk("rst_stb", 32'(STB_O), 32'(0));
    chk("rst_cab", 32'(CAB_O), 32'(0));
    chk("rst_adr", 32'(ADR_O), 32'(0));
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_sint", 32'(SINT), 32'(0));
    chk("we_o", 32'(WE_O), 32'(0));
    chk("sel_o", 32'(SEL_O), 32'hF);
    #2 nRESET = 1'b1;

    // Single 4-beat vmem burst.
    @(negedge CLK_I); #2;
    blen0 = 2'b10; adr0 = 30'h100;
    for (int i = 0; i < 4; i++) push_ack(3'b001, 30'h100 + 30'(i), 1'b1);
    req = 3'b001;
    @(negedge CLK_I); #2;
    chk("t1_latency_cyc", 32'(CYC_O), 32'(1));
    chk("t1_stb", 32'(STB_O), 32'(1));
    chk("t1_gnt", 32'(gnt), 32'(3'b001));
    chk("t1_cab", 32'(CAB_O), 32'(1));
    req = 3'b000;
    wait_done("t1_done");
    chk("t1_gnt_released", 32'(gnt), 32'(0));
    chk("t1_cab_released", 32'(CAB_O), 32'(0));

    // Simultaneous requests: vmem, cursor, clut with one idle cycle between.
    blen0 = 2'b00; adr0 = 30'h10;
    blen1 = 2'b01; adr1 = 30'h20;
    blen2 = 2'b00; adr2 = 30'h30;
    push_ack(3'b001, 30'h10, 1'b0);
    push_ack(3'b010, 30'h20, 1'b1);
    push_ack(3'b010, 30'h21, 1'b1);
    push_ack(3'b100, 30'h30, 1'b0);
    req = 3'b111;
    wait_owner(3'b001, "t2_vmem");
    req[0] = 1'b0;
    gap_chk = 1'b1;
    wait_owner(3'b010, "t2_cursor");
    req[1] = 1'b0;
    wait_owner(3'b100, "t2_clut");
    req[2] = 1'b0;
    wait_done("t2_done");
    gap_chk = 1'b0;

    // Starvation: everyone keeps requesting; clut wins after 4 vmem grants.
    for (int i = 0; i < 4; i++) push_ack(3'b001, 30'h10, 1'b0);
    push_ack(3'b100, 30'h30, 1'b0);
    req = 3'b111;
    for (int g = 0; g < 5; g++) begin
      wait_owner(3'b111, "t3_grant");
      if (g == 4) begin
        chk("t3_starve_winner", 32'(gnt), 32'(3'b100));
        req = 3'b000;
      end
      @(negedge CLK_I); #2;
    end
    wait_done("t3_done");

    // ERR_I on beat 2 of an 8-beat cursor burst.
    slave_mode = 1; err_after = 1;
    blen1 = 2'b11; adr1 = 30'h200;
    push_ack(3'b010, 30'h200, 1'b1);
    push_err(3'b010);
    req = 3'b010;
    wait_owner(3'b010, "t4_cursor");
    req = 3'b000;
    wait_done("t4_done");
    slave_mode = 0;

    // Watchdog: no ACK_I, TO_W=3 -> bus held for 7 cycles then error.
    slave_mode = 2;
    blen0 = 2'b00; adr0 = 30'h300;
    push_err(3'b001);
    req = 3'b001;
    wait_owner(3'b001, "t5_vmem");
    req = 3'b000;
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK_I); #2;
      if (CYC_O) cnt++;
      else break;
    end
    chk("t5_wd_cycles", 32'(cnt), 32'(7));
    chk("t5_gnt_released", 32'(gnt), 32'(0));
    wait_done("t5_done");
    slave_mode = 0;

    // Address wrap.
    blen0 = 2'b01; adr0 = 30'h3FFFFFFF;
    push_ack(3'b001, 30'h3FFFFFFF, 1'b1);
    push_ack(3'b001, 30'h0, 1'b1);
    req = 3'b001;
    wait_owner(3'b001, "t6_vmem");
    req = 3'b000;
    wait_done("t6_done");

    // ctrl_ven drop mid-burst; the ack in the abort cycle still arrives.
    blen0 = 2'b11; adr0 = 30'h400;
    for (int i = 0; i < 3; i++) push_ack(3'b001, 30'h400 + 30'(i), 1'b1);
    req = 3'b001;
    wait_owner(3'b001, "t7_vmem");
    req = 3'b000;
    @(negedge CLK_I);
    @(negedge CLK_I);
    ctrl_ven = 1'b0;
    @(negedge CLK_I); #2;
    chk("t7_abort_cyc", 32'(CYC_O), 32'(0));
    chk("t7_abort_gnt", 32'(gnt), 32'(0));
    chk("t7_abort_sint", 32'(SINT), 32'(0));
    ctrl_ven = 1'b1;
    wait_done("t7_done");

    // Asynchronous reset mid-burst clears outputs immediately.
    adr0 = 30'h500;
    push_ack(3'b001, 30'h500, 1'b1);
    push_ack(3'b001, 30'h501, 1'b1);
    req = 3'b001;
    wait_owner(3'b001, "t8_vmem");
    req = 3'b000;
    @(negedge CLK_I); #2;
    nRESET = 1'b0;
    #1;
    chk("t8_rst_cyc", 32'(CYC_O), 32'(0));
    chk("t8_rst_stb", 32'(STB_O), 32'(0));
    chk("t8_rst_cab", 32'(CAB_O), 32'(0));
    chk("t8_rst_gnt", 32'(gnt), 32'(0));
    chk("t8_rst_adr", 32'(ADR_O), 32'(0));
    @(negedge CLK_I); #2;
    nRESET = 1'b1;

    // Synchronous reset blocks a grant.
    blen0 = 2'b00; adr0 = 30'h600;
    req = 3'b001; RST_I = 1'b1;
    @(negedge CLK_I); #2;
    chk("t9_srst_cyc", 32'(CYC_O), 32'(0));
    chk("t9_srst_gnt", 32'(gnt), 32'(0));
    req = 3'b000; RST_I = 1'b0;

    repeat (4) @(negedge CLK_I);
    chk("sb_empty", 32'(sb_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_wb_arbiter.md
Name: vga_wb_arbiter

Overview:
Shares the VGA core's single WISHBONE master port between three internal read requesters: the video-memory fetch, the hardware-cursor fetch and the CLUT lookup. The block selects one owner and sequences its burst (1/2/4/8 beats) with address auto-increment. It routes ACK/ERR back to the owner only. It enforces fairness so the CLUT is never starved, and runs a bus watchdog that raises SINT on ERR_I or timeout.

Parameters:
TO_W, 8, width of bus watchdog counter; timeout after 2^TO_W-1 cycles without ACK_I/ERR_I
STARVE_MAX, 4, consecutive lost arbitrations after which a waiting CLUT request wins unconditionally

Ports:
CLK_I  in  1  master clock, all logic on rising edge
nRESET  in  1  asynchronous active-low reset
RST_I  in  1  synchronous active-high reset, same effect as nRESET
ctrl_ven  in  1  video enable; low = masks requests and aborts any cycle
req  in  3  request per requester: [0] vmem, [1] cursor, [2] clut; level, held until granted
blen0, blen1, blen2  in  2 each  burst code per requester: 00=1, 01=2, 10=4, 11=8 beats
adr0, adr1, adr2  in  30 each  start word address [31:2] per requester, sampled at grant
gnt  out  3  one-hot current owner, 000 when bus idle
ack  out  3  ACK_I & gnt (combinational), per-requester data strobe
err  out  3  one-cycle pulse to owner on ERR_I or timeout
CYC_O, STB_O  out  1  WISHBONE cycle/strobe (identical, registered)
CAB_O  out  1  high for the whole cycle when burst length > 1
WE_O  out  1  constant 0
SEL_O  out  4  constant 4'b1111
ADR_O  out  30  current beat word address (registered)
ACK_I, ERR_I  in  1  WISHBONE acknowledge / error
SINT  out  1  one-cycle pulse on any err pulse

Behaviour:
- Reset (nRESET low async, or RST_I high sync): state IDLE; CYC_O=STB_O=CAB_O=0, ADR_O=0, gnt=0, err=0, SINT=0, beat/watchdog/starve counters=0.
- States: IDLE, BUS.
- IDLE, ctrl_ven=1, req!=0: winner = clut if req[2] and starve_cnt==STARVE_MAX. Otherwise fixed priority vmem > cursor > clut.
- Next cycle: state BUS; gnt=winner; CYC_O=STB_O=1; ADR_O=adrN; beat_cnt=beats-1; CAB_O=(blenN!=00); watchdog=0. Latency req->CYC_O = 1 cycle.
- starve_cnt: +1 (saturating at STARVE_MAX) on each grant to a non-clut requester while req[2]=1; cleared on clut grant or when req[2]=0.
- BUS, ACK_I=1, beat_cnt!=0: ADR_O+1 (30-bit wrap, 0x3FFFFFFF->0), beat_cnt-1, watchdog cleared.
- BUS, ACK_I=1, beat_cnt==0: last beat. Next cycle CYC_O=STB_O=CAB_O=0, gnt=0, state IDLE.
- IDLE always lasts at least one cycle between owners. Back-to-back cycles therefore have exactly one idle bus cycle.
- Once granted, a burst always completes. Requester req changes during BUS are ignored. The requester must accept all ack beats.
- BUS, ERR_I=1 (priority over ACK_I if both high): err[owner] pulses (registered, next cycle) and SINT pulses. The cycle terminates as on the last beat and no ack is delivered for that beat.
- Watchdog increments every BUS cycle without ACK_I/ERR_I. On reaching 2^TO_W-1, it is treated exactly as ERR_I.
- ctrl_ven low in any state: next cycle CYC_O=STB_O=CAB_O=0, gnt=0, state IDLE, starve_cnt=0. No err/SINT. ack stays gated by gnt, so an ACK_I in the abort cycle is still delivered.
- ADR_O holds its last value in IDLE.

Test Plan:
- Single vmem burst: req=001, blen0=10, adr0=0x100, ACK_I every cycle -> CYC_O 1 cycle after req, ADR_O 0x100..0x103, ack[0] 4 pulses, CAB_O=1, CYC_O low after 4th ACK, gnt=000.
- Simultaneous req=111 -> vmem, cursor, clut granted in that order, each separated by exactly one idle cycle.
- Starvation: vmem+cursor re-requesting continuously, clut pending, STARVE_MAX=4 -> clut granted after 4th non-clut grant. Single beat, CAB_O=0.
- ERR_I on beat 2 of an 8-beat cursor burst -> err[1] and SINT one-cycle pulses, CYC_O low next cycle, only 1 ack[1] delivered.
- Watchdog, TO_W=3, no ACK_I -> err/SINT pulse after 7 stalled cycles, bus released.
- Wrap and abort: adr0=0x3FFFFFFF, blen=01 -> ADR_O 0x3FFFFFFF then 0x00000000. ctrl_ven dropped mid-burst -> CYC_O=0 next cycle, no SINT. nRESET asserted mid-burst -> outputs zero immediately.
